// File: rtl/mm_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter FSM states and frame constants.
package mm_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STAT_OVF       = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_BUSY      = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_W   = 4;
  localparam int unsigned STAT_PARITY_EN = 15;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mm_uart_tx_fifo.sv
// Transmit byte FIFO for mm_uart_tx; pointers wrap modulo DEPTH (2, 4 or 8).
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == 4'(DEPTH));
  assign empty = (count_q == 4'd0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a four-word register window.
// Define MM_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mm_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter logic [15:0] BAUD_DIV   = 16'd434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic        tx
);
  import mm_uart_pkg::*;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
`ifdef MM_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        sel, wr, push_req, fifo_push, pop, load, bit_done;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_count;
  logic [15:0] status;

  assign sel      = (addr[15:2] == BASE_ADDR[15:2]);
  assign wr       = sel && mm_we;
  assign push_req = wr && (addr[1:0] == REG_TXDATA);
  // A push into a full FIFO still lands when the transmitter pops the head on the same edge.
  assign fifo_push = push_req && (!fifo_full || pop);
  assign tx        = tx_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr && addr[1:0] == REG_BAUD) baud_d = wdata;
    if (wr && addr[1:0] == REG_STATUS && wdata[0]) ovf_d = 1'b0;
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
  end

  assign bit_done = (baud_cnt_q == div_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
`ifdef MM_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    load = 1'b0;
    pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        load       = !fifo_empty;
      end
      ST_START: begin
        if (bit_done) begin
          state_d    = ST_DATA;
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef MM_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef MM_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d    = ST_STOP;
          baud_cnt_d = '0;
          tx_d       = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
          load       = !fifo_empty;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
      end
    endcase
    // Frame start is shared by IDLE and end-of-STOP so back-to-back frames have no gap.
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      shift_d    = fifo_dout;
      div_d      = (baud_q == '0) ? 16'd1 : baud_q;
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
      tx_d       = 1'b0;
`ifdef MM_UART_TX_PARITY_EN
      par_d      = even_parity(fifo_dout);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= BAUD_DIV;
      div_q      <= 16'd1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
`ifdef MM_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
`ifdef MM_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    status                                = '0;
    status[STAT_OVF]                      = ovf_q;
    status[STAT_EMPTY]                    = fifo_empty;
    status[STAT_FULL]                     = fifo_full;
    status[STAT_BUSY]                     = (state_q != ST_IDLE);
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = fifo_count;
`ifdef MM_UART_TX_PARITY_EN
    status[STAT_PARITY_EN]                = 1'b1;
`endif
    rdata = '0;
    if (sel && mm_re) begin
      case (addr[1:0])
        REG_STATUS: rdata = status;
        REG_BAUD:   rdata = baud_q;
        REG_RSVD:   rdata = '0;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/mm_uart_tx.md
# mm_uart_tx

Memory-mapped UART transmitter peripheral on the CPU's external data-memory bus, i.e. the responder side of the `addr`/`wdata`/`mm_we`/`mm_re`/`rdata` interface the CPU drives for addresses with `addr[15:13]` nonzero. Software writes bytes into a small transmit FIFO, and the block serialises them onto `tx` as 8N1 frames. Status and baud divisor are readable and writable through the same four-word register window.

## Interface
- `BASE_ADDR`, default 16'hC000: window base. Bits [1:0] are ignored and bits [15:13] must be nonzero.
- `BAUD_DIV`, default 16'd434: reset value of the BAUD register, in clocks per bit.
- `FIFO_DEPTH`, default 4: transmit FIFO entries. Legal values are 2, 4 or 8.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset. Asynchronous assertion, active-high.
- `addr` in 16: bus address. Selected when `addr[15:2] == BASE_ADDR[15:2]`.
- `wdata` in 16: write data.
- `mm_we` in 1: write strobe, sampled at the rising edge.
- `mm_re` in 1: read strobe.
- `rdata` out 16: read data, combinational.
- `tx` out 1: serial output. Idle high.

## Operation
- Register map, by `addr[1:0]`:
  - 0 TXDATA: write pushes `wdata[7:0]`; read returns 0.
  - 1 STATUS: read returns `{8'b0, count[3:0], busy, full, empty, ovf}`. A write with `wdata[0]=1` clears `ovf`.
  - 2 BAUD: read/write 16-bit divisor.
  - 3 reserved: reads 0, writes ignored.
- `rdata` is `16'h0000` whenever `mm_re=0` or the address is not selected, so rdata can be OR-combined with other peripherals.
- Reads have no side effects, so repeated `mm_re` during CPU stalls is harmless.
- FIFO:
  - A push when full and no pop in the same cycle drops the byte and sets sticky `ovf`.
  - A push while full in the same cycle as a pop is accepted.
  - A push and pop together when empty is impossible, because a pop requires non-empty at the edge.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE→START when the FIFO is non-empty. At that edge: pop the head into the shift register, latch `div_act = (BAUD==0) ? 1 : BAUD`, clear the bit counter, drive `tx=0`.
  - START→DATA after `div_act` clocks.
  - DATA shifts LSB first, one bit per `div_act` clocks. After bit 7 completes, go to STOP.
  - STOP drives `tx=1` for `div_act` clocks. Then go to START with an immediate pop if the FIFO is non-empty (no idle gap), otherwise to IDLE.
- `busy` = state != IDLE.
- A BAUD write mid-frame affects only the next frame.
- Reset values: `tx=1`, state IDLE, FIFO empty (count 0), `ovf=0`, BAUD=`BAUD_DIV`, bit and baud counters 0, `rdata=0`.
- Reset mid-frame: `tx` returns high asynchronously, FIFO contents are discarded, and no partial frame resumes.

## Timing
- A write takes effect at the edge where `mm_we` is sampled. STATUS reflects it in the following cycle.
- With the FIFO empty and state IDLE, a TXDATA write at edge k makes `tx` fall at edge k+1.
- A frame is exactly `10*div_act` clocks (`11*div_act` with parity).
- Back-to-back frames are contiguous.
- `rdata` settles combinationally in the same cycle as `addr`/`mm_re`, matching the CPU's same-cycle read mux.

## Configuration
- `MM_UART_TX_PARITY_EN`:
  - Defined: an even-parity bit (XOR of the 8 data bits) is sent between DATA and STOP, in state PARITY, for `div_act` clocks. STATUS bit 15 reads 1.
  - Undefined: the PARITY state and its logic are absent, and STATUS bit 15 reads 0.

## Structure
- Package `mm_uart_pkg`: register offsets, STATUS bit positions, FSM state enum (PARITY is included unconditionally), and the 8N1 bit-count constant.
- Sub-module `uart_tx_fifo`:
  - Parameterised by depth.
  - Ports: push, pop, din[7:0], dout[7:0], full, empty, count.
  - Pointer wrap-around is by modulo depth.
- The top level holds address decode, the register bank, the FSM, the baud counter and the shift register.

## Test plan
- Reset: `tx=1`, STATUS read = 16'h0002, BAUD read = 434. Assert `rst` mid-frame → `tx=1` within the same cycle and STATUS=16'h0002 afterwards.
- BAUD=2, write TXDATA 8'hA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 2 clocks, falling at edge k+1. Total 20 clocks, then `busy=0`.
- BAUD=1, write 8'h00 then 8'hFF back-to-back → 20 contiguous bit times with no idle high between the frames.
- With FIFO_DEPTH=4 and a transfer in flight, push 5 bytes rapidly → count=4, `full=1`, `ovf=1`, and the fifth byte is never transmitted. Write STATUS 16'h0001 → `ovf=0`.
- Read from `BASE_ADDR+3`, from an unselected address 16'hE000, and with `mm_re=0` → `rdata=0` in all three cases.
- Change BAUD from 2 to 4 mid-frame → the current frame stays at 2 clocks per bit and the next frame runs at 4 clocks per bit. With `MM_UART_TX_PARITY_EN` defined, 8'h07 emits parity bit 1.
